// File: rtl/lr_pkg.sv
// Shared types and constants for the logistic-regression class scheduler.
package lr_pkg;

    localparam int unsigned NTAP    = 81;
    localparam int unsigned PIX_W   = 7;
    localparam int unsigned SCORE_W = 32;
    localparam int unsigned CLS_W   = 4;
    localparam int unsigned WIN_W   = NTAP * PIX_W;
    localparam int unsigned CNT_W   = 3;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [CLS_W-1:0]          cls_t;
    typedef logic [WIN_W-1:0]          win_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        cls_t   cls;
        score_t score;
    } res_t;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/lr_class_sched_if.sv
// Window, datapath and result signals of the class scheduler.
interface lr_class_sched_if;
    import lr_pkg::*;

    logic   win_valid;
    logic   win_ready;
    win_t   win_data;
    win_t   dp_win;
    cls_t   dp_sel;
    score_t dp_score;
    logic   res_valid;
    logic   res_ready;
    cls_t   res_class;
    score_t res_score;
    logic   busy;

    modport slave (
        input  win_valid, win_data, dp_score, res_ready,
        output win_ready, dp_win, dp_sel, res_valid, res_class, res_score, busy
    );

    modport master (
        output win_valid, win_data, dp_score, res_ready,
        input  win_ready, dp_win, dp_sel, res_valid, res_class, res_score, busy
    );

endinterface

// File: rtl/lr_argmax_acc.sv
// Running argmax over per-class scores; strict greater-than keeps the lower index on ties.
module lr_argmax_acc
    import lr_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   sample,
    input  score_t score,
    input  cls_t   cls,
    output score_t upd_score_c,
    output cls_t   upd_class_c
);

    score_t best_score;
    cls_t   best_class;

    // Best including the current sample, so the final class can be folded in the same cycle.
    always_comb begin
        upd_score_c = best_score;
        upd_class_c = best_class;
        if (score > best_score) begin
            upd_score_c = score;
            upd_class_c = cls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_score <= SCORE_MIN;
            best_class <= '0;
        end else if (sample) begin
            best_score <= upd_score_c;
            best_class <= upd_class_c;
        end
    end

endmodule

// File: rtl/lr_class_sched.sv
// Steps one shared inner-product datapath through every class weight set and reports the argmax.
module lr_class_sched
    import lr_pkg::*;
#(
    parameter int unsigned NCLASS = 10,
    parameter int unsigned DP_LAT = 2
) (
    input logic             clk,
    input logic             rst,
    lr_class_sched_if.slave bus
);

    localparam cls_t LAST_CLS = CLS_W'(NCLASS - 1);

    state_t             state_q, state_d;
    win_t               win_q;
    cls_t               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    res_t               res_q, res_d;
    logic               win_ready_q, busy_q, res_valid_q;
    logic               load_win_c, clear_c, sample_c;
    score_t             upd_score_c;
    cls_t               upd_class_c;

    lr_argmax_acc u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_c),
        .sample      (sample_c),
        .score       (bus.dp_score),
        .cls         (sel_q),
        .upd_score_c (upd_score_c),
        .upd_class_c (upd_class_c)
    );

    // Next-state and sampling decisions.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        load_win_c = 1'b0;
        clear_c    = 1'b0;
        sample_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.win_valid) begin
                    load_win_c = 1'b1;
                    clear_c    = 1'b1;
                    sel_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (DP_LAT == 0) begin
                    sample_c = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(DP_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    sample_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sample either advances to the next class or closes out the window.
        if (sample_c) begin
            if (sel_q == LAST_CLS) begin
                res_d   = '{cls: upd_class_c, score: upd_score_c};
                state_d = DONE;
            end else begin
                sel_d   = sel_q + CLS_W'(1);
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            win_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            win_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            res_valid_q <= (state_d == DONE);
            if (load_win_c) begin
                win_q <= bus.win_data;
            end
        end
    end

    assign bus.win_ready = win_ready_q;
    assign bus.busy      = busy_q;
    assign bus.dp_win    = win_q;
    assign bus.dp_sel    = sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = res_q.cls;
    assign bus.res_score = res_q.score;

endmodule

// File: tb/tb_lr_class_sched.sv
// Directed bench for lr_class_sched: DP_LAT=2/NCLASS=10 instance plus a DP_LAT=0/NCLASS=2 instance.
module tb_lr_class_sched;
    import lr_pkg::*;

    localparam int unsigned CW = WIN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lr_class_sched_if b0 ();
    lr_class_sched_if b1 ();

    lr_class_sched #(.NCLASS(10), .DP_LAT(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    lr_class_sched #(.NCLASS(2),  .DP_LAT(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // Behavioural datapath: score of a class appears DP_LAT cycles after dp_sel selects it.
    score_t tbl0 [16];
    score_t tbl1 [16];
    cls_t   sel_d1, sel_d2;
    always @(posedge clk) begin
        sel_d1 <= b0.dp_sel;
        sel_d2 <= sel_d1;
    end
    assign b0.dp_score = tbl0[sel_d2];
    assign b1.dp_score = tbl1[b1.dp_sel];

    int n_chk  = 0;
    int n_pass = 0;

    int sc_a [10] = '{5, -3, 12, 7, 0, 12, 1, 2, 3, 4};
    int sc_n [10] = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    int sc_b [10] = '{-5, 2, 1, 9, -1, 4, 20, 0, 20, 11};
    int sc_r [10] = '{7, -2, 33, 33, 0, 5, 33, -40, 1, 32};

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input int s [10]);
        for (int i = 0; i < 10; i++) tbl0[i] = score_t'(s[i]);
    endtask

    function automatic win_t rand_win();
        win_t r;
        r = '0;
        for (int unsigned k = 0; k < NTAP; k++) r[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 127));
        return r;
    endfunction

    // Accept one window on u0 from IDLE and wait (bounded) for its result.
    task automatic run_window(input string tag, input win_t w, input int exp_cls, input int exp_score);
        int n, sel_err, win_err;
        b0.win_data  = w;
        b0.win_valid = 1'b1;
        tick();
        b0.win_valid = 1'b0;
        n = 1; sel_err = 0; win_err = 0;
        while (!b0.res_valid && n < 200) begin
            if (b0.dp_sel !== cls_t'((n - 1) / 3)) sel_err++;
            if (b0.dp_win !== w) win_err++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, CW'(n), CW'(31));
        chk({tag, "_dpsel_seq"}, CW'(sel_err), CW'(0));
        chk({tag, "_dpwin_hold"}, CW'(win_err), CW'(0));
        chk({tag, "_class"}, CW'(b0.res_class), CW'(exp_cls));
        chk({tag, "_score"}, CW'(b0.res_score), CW'(exp_score));
    endtask

    initial begin
        win_t w1, w2, w3, exp_win, d;
        int   hold_err, pulses, last, int_err, win_err, sel_err, rv_err, res_err, results, phase, n;
        logic acc;

        for (int i = 0; i < 16; i++) begin
            tbl0[i] = '0;
            tbl1[i] = '0;
        end
        tbl1[0] = score_t'(1);
        tbl1[1] = score_t'(1);
        b0.win_valid = 1'b0; b0.win_data = '0; b0.res_ready = 1'b0;
        b1.win_valid = 1'b0; b1.win_data = '0; b1.res_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick(); tick();
        chk("rst_win_ready", CW'(b0.win_ready), CW'(1));
        chk("rst_res_valid", CW'(b0.res_valid), CW'(0));
        chk("rst_res_class", CW'(b0.res_class), CW'(0));
        chk("rst_res_score", CW'(b0.res_score), CW'(0));
        chk("rst_dp_sel", CW'(b0.dp_sel), CW'(0));
        chk("rst_dp_win", b0.dp_win, CW'(0));
        chk("rst_busy", CW'(b0.busy), CW'(0));
        chk("rst1_win_ready", CW'(b1.win_ready), CW'(1));
        rst = 1'b0;
        tick();

        // First window: tie between classes 2 and 5 keeps 2.
        load0(sc_a);
        w1 = rand_win();
        run_window("tie", w1, 2, 12);

        // Result held while res_ready is low; a pending window is not taken.
        w2 = rand_win();
        b0.win_data  = w2;
        b0.win_valid = 1'b1;
        load0(sc_n);
        hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            if (b0.res_valid !== 1'b1 || b0.res_class !== cls_t'(2) || b0.res_score !== score_t'(12) ||
                b0.win_ready !== 1'b0 || b0.busy !== 1'b1 || b0.dp_win !== w1) hold_err++;
            tick();
        end
        chk("hold_stable", CW'(hold_err), CW'(0));
        b0.res_ready = 1'b1;
        tick();
        b0.res_ready = 1'b0;
        chk("rel_res_valid", CW'(b0.res_valid), CW'(0));
        chk("rel_win_ready", CW'(b0.win_ready), CW'(1));
        chk("rel_dp_win_kept", b0.dp_win, w1);

        // All-negative scores: best must start at the most negative value.
        run_window("neg", w2, 9, -91);
        b0.res_ready = 1'b1;
        tick();
        chk("neg_release", CW'(b0.res_valid), CW'(0));

        // Back-to-back windows with continuous valid/ready.
        load0(sc_b);
        b0.win_valid = 1'b1;
        exp_win = w2;
        pulses = 0; last = -1; int_err = 0; win_err = 0; sel_err = 0;
        rv_err = 0; res_err = 0; results = 0; phase = 0;
        for (int c = 0; c < 100; c++) begin
            d = rand_win();
            b0.win_data = d;
            acc = b0.win_ready;
            if (acc) begin
                pulses++;
                if (last >= 0 && c - last != 32) int_err++;
                last = c;
            end
            tick();
            if (acc) begin
                exp_win = d;
                phase = 1;
            end else if (phase > 0) begin
                phase++;
            end
            if (b0.dp_win !== exp_win) win_err++;
            if (phase >= 1 && phase <= 30 && b0.dp_sel !== cls_t'((phase - 1) / 3)) sel_err++;
            if (b0.res_valid !== (phase == 31)) rv_err++;
            if (phase == 31) begin
                results++;
                if (b0.res_class !== cls_t'(6) || b0.res_score !== score_t'(20)) res_err++;
            end
        end
        b0.win_valid = 1'b0;
        chk("b2b_pulses", CW'(pulses), CW'(4));
        chk("b2b_interval", CW'(int_err), CW'(0));
        chk("b2b_dp_win", CW'(win_err), CW'(0));
        chk("b2b_dp_sel", CW'(sel_err), CW'(0));
        chk("b2b_res_valid", CW'(rv_err), CW'(0));
        chk("b2b_results", CW'(results), CW'(3));
        chk("b2b_result_val", CW'(res_err), CW'(0));

        // Reset while waiting on class 4.
        n = 0;
        while (b0.dp_sel !== cls_t'(4) && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("mid_sel4", CW'(b0.dp_sel), CW'(4));
        chk("mid_busy", CW'(b0.busy), CW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_win_ready", CW'(b0.win_ready), CW'(1));
        chk("mid_rst_dp_sel", CW'(b0.dp_sel), CW'(0));
        chk("mid_rst_res_valid", CW'(b0.res_valid), CW'(0));
        chk("mid_rst_busy", CW'(b0.busy), CW'(0));
        load0(sc_r);
        w3 = rand_win();
        run_window("post_rst", w3, 2, 33);
        tick();
        chk("post_rst_release", CW'(b0.res_valid), CW'(0));

        // Zero-latency datapath, two equal scores.
        b1.win_data  = rand_win();
        b1.win_valid = 1'b1;
        tick();
        b1.win_valid = 1'b0;
        n = 1;
        while (!b1.res_valid && n < 50) begin
            tick();
            n++;
        end
        chk("lat0_latency", CW'(n), CW'(3));
        chk("lat0_class", CW'(b1.res_class), CW'(0));
        chk("lat0_score", CW'(b1.res_score), CW'(1));
        b1.res_ready = 1'b1;
        tick();
        chk("lat0_release", CW'(b1.win_ready), CW'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
